serial_tx_shift_control: RTL and testbench

// - Transmit engine of the serial block; sits directly upstream of the serial output logic control.
// - Loads SBUF on a CPU write and shifts the frame out on bit-rate ticks.
// - Drives the data, send and data-enable qualifiers and the TI flag consumed by the output stage.
// - Supports mode 0 (8-bit synchronous) and mode 2 (11-bit asynchronous: start, 8 data, TB8, stop).

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_tx_bit_counter.sv | 35 +++
 rtl/serial_tx_shift_control.sv | 152 +++++++++++++++
 tb/tb_serial_tx_shift_control.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial transmit block: FSM state encoding, mode selects and default SBUF width.
package serial_pkg;

    localparam int SERIAL_DATA_W = 8;

    localparam logic SERIAL_MODE0 = 1'b0;
    localparam logic SERIAL_MODE2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        NINTH = 3'd4,
        STOP  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/serial_tx_bit_counter.sv
// Tick-enabled data-bit counter; terminal count flags the last data bit of a frame.
module serial_tx_bit_counter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_tx_shift_control.sv
// Serial transmit engine: loads SBUF on a CPU write and shifts mode 0 / mode 2 frames out on bit ticks.
// Define SERIAL_TX_WCOL_EN to enable the sticky write-collision flag on serial_tx_wcol_o.
module serial_tx_shift_control
    import serial_pkg::*;
#(
    parameter int   DATA_W   = SERIAL_DATA_W,
    parameter logic STOP_LVL = 1'b1
) (
    input  logic              serial_clock_internal_i,
    input  logic              serial_reset_internal_i_b,
    input  logic              serial_br_trans_internal_i,
    input  logic              serial_scon7_sm0_internal_i,
    input  logic              serial_scon3_tb8_internal_i,
    input  logic [DATA_W-1:0] serial_sbuf_tx_internal_i,
    input  logic              serial_sbuf_wr_internal_i,
    input  logic              serial_ti_clr_internal_i,
    output logic              serial_data_tx_internal_o,
    output logic              serial_send_internal_o,
    output logic              serial_data_en_internal_o,
    output logic              serial_scon1_ti_o_internal_o,
    output logic              serial_tx_busy_o,
    output logic              serial_tx_wcol_o
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              mode_q, mode_d;
    logic              tb8_q, tb8_d;
    logic              ti_q, ti_d;
    logic              send_q, send_d;
    logic              data_en_q, data_en_d;
    logic              data_tx_q, data_tx_d;
    logic              busy_q, busy_d;
    logic              ti_set, cnt_clr, cnt_en, cnt_tc, wr_accept;

    serial_tx_bit_counter #(.DATA_W(DATA_W)) u_bit_counter (
        .clk   (serial_clock_internal_i),
        .rst_n (serial_reset_internal_i_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        tb8_d     = tb8_q;
        ti_set    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        wr_accept = 1'b0;

        case (state_q)
            IDLE: ;
            ARM: if (serial_br_trans_internal_i) begin
                cnt_clr = 1'b1;
                tb8_d   = serial_scon3_tb8_internal_i;
                state_d = (mode_q == SERIAL_MODE2) ? START : DATA;
            end
            START: if (serial_br_trans_internal_i) state_d = DATA;
            DATA: if (serial_br_trans_internal_i) begin
                cnt_en  = 1'b1;
                shift_d = shift_q >> 1;
                if (cnt_tc) begin
                    if (mode_q == SERIAL_MODE2) begin
                        state_d = NINTH;
                    end else begin
                        state_d = IDLE;
                        ti_set  = 1'b1;
                    end
                end
            end
            NINTH: if (serial_br_trans_internal_i) state_d = STOP;
            STOP: if (serial_br_trans_internal_i) begin
                state_d = IDLE;
                ti_set  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A write is taken whenever the engine is, or is just becoming, idle.
        wr_accept = serial_sbuf_wr_internal_i && (state_d == IDLE);
        if (wr_accept) begin
            state_d = ARM;
            shift_d = serial_sbuf_tx_internal_i;
            mode_d  = serial_scon7_sm0_internal_i;
        end

        ti_d      = ti_set | (ti_q & ~serial_ti_clr_internal_i);
        busy_d    = (state_d != IDLE);
        send_d    = state_d inside {START, DATA, NINTH, STOP};
        data_en_d = state_d inside {DATA, NINTH, STOP};
        case (state_d)
            DATA:    data_tx_d = shift_d[0];
            NINTH:   data_tx_d = tb8_d;
            STOP:    data_tx_d = STOP_LVL;
            default: data_tx_d = 1'b0;
        endcase
    end

    always_ff @(posedge serial_clock_internal_i or negedge serial_reset_internal_i_b) begin
        if (!serial_reset_internal_i_b) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            mode_q    <= SERIAL_MODE0;
            tb8_q     <= 1'b0;
            ti_q      <= 1'b0;
            send_q    <= 1'b0;
            data_en_q <= 1'b0;
            data_tx_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            mode_q    <= mode_d;
            tb8_q     <= tb8_d;
            ti_q      <= ti_d;
            send_q    <= send_d;
            data_en_q <= data_en_d;
            data_tx_q <= data_tx_d;
            busy_q    <= busy_d;
        end
    end

    assign serial_data_tx_internal_o    = data_tx_q;
    assign serial_send_internal_o       = send_q;
    assign serial_data_en_internal_o    = data_en_q;
    assign serial_scon1_ti_o_internal_o = ti_q;
    assign serial_tx_busy_o             = busy_q;

`ifdef SERIAL_TX_WCOL_EN
    logic wcol_q, wcol_d;

    always_comb begin
        wcol_d = (serial_sbuf_wr_internal_i & ~wr_accept) | (wcol_q & ~serial_ti_clr_internal_i);
    end

    always_ff @(posedge serial_clock_internal_i or negedge serial_reset_internal_i_b) begin
        if (!serial_reset_internal_i_b) begin
            wcol_q <= 1'b0;
        end else begin
            wcol_q <= wcol_d;
        end
    end

    assign serial_tx_wcol_o = wcol_q;
`else
    assign serial_tx_wcol_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_shift_control.sv
// Scoreboard bench for serial_tx_shift_control: stimulus queues expected outputs, a monitor compares them.
module tb_serial_tx_shift_control;

`ifdef SERIAL_TX_WCOL_EN
    localparam logic WcolOn = 1'b1;
`else
    localparam logic WcolOn = 1'b0;
`endif

    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       br = 1'b0, wr = 1'b0, sm0 = 1'b0, tb8 = 1'b0, clr = 1'b0;
    logic [7:0] sbuf = 8'h00;
    logic       data_tx, send, data_en, ti, busy, wcol;

    exp_t       scoreboard[$];
    logic       evQ = 1'b0;
    logic       expTi = 1'b0;
    logic       expWcol = 1'b0;
    int         errors = 0;
    int         checks = 0;

    serial_tx_shift_control dut (
        .serial_clock_internal_i      (clk),
        .serial_reset_internal_i_b    (rst_n),
        .serial_br_trans_internal_i   (br),
        .serial_scon7_sm0_internal_i  (sm0),
        .serial_scon3_tb8_internal_i  (tb8),
        .serial_sbuf_tx_internal_i    (sbuf),
        .serial_sbuf_wr_internal_i    (wr),
        .serial_ti_clr_internal_i     (clr),
        .serial_data_tx_internal_o    (data_tx),
        .serial_send_internal_o       (send),
        .serial_data_en_internal_o    (data_en),
        .serial_scon1_ti_o_internal_o (ti),
        .serial_tx_busy_o             (busy),
        .serial_tx_wcol_o             (wcol)
    );

    always #5 clk = ~clk;

    // Expected vector order: send, data_en, data_tx, ti, busy, wcol
    function automatic logic [5:0] ev(input logic s, input logic de, input logic dt, input logic b);
        return {s, de, dt, expTi, b, expWcol};
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [5:0] act;
        act = {send, data_en, data_tx, ti, busy, wcol};
        checks++;
        if (act !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: send/den/dtx/ti/busy/wcol got %b expected %b", e.tag, act, e.v);
        end
    endtask

    // Any cycle carrying a tick, write or clear is a DUT event with one queued expectation.
    always @(posedge clk) evQ <= br | wr | clr;

    always @(negedge clk) begin
        if (evQ) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got empty scoreboard expected an entry");
            end else begin
                checkOutput(scoreboard.pop_front());
            end
        end
    end

    // Drives one clock of inputs starting at a negedge; queues the expected post-edge outputs.
    task automatic applyStimulus(input logic t, input logic w, input logic [7:0] d, input logic m,
                                 input logic c, input logic [5:0] e, input string tag);
        exp_t x;
        br = t; wr = w; clr = c;
        if (w) begin
            sbuf = d;
            sm0  = m;
        end
        if (t | w | c) begin
            x.v   = e;
            x.tag = tag;
            scoreboard.push_back(x);
        end
        @(negedge clk);
        br = 1'b0; wr = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tickBit(input int gap, input logic [5:0] e, input string tag);
        idle(gap - 1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, e, tag);
    endtask

    task automatic writeByte(input logic [7:0] d, input logic m, input logic t8);
        tb8 = t8;
        applyStimulus(1'b0, 1'b1, d, m, 1'b0, ev(0, 0, 0, 1), $sformatf("write_%h", d));
    endtask

    task automatic dataBits(input logic [7:0] b, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            tickBit(gap, ev(1, 1, b[i], 1), $sformatf("data_%h_bit%0d", b, i));
        end
    endtask

    task automatic clearFlags();
        expTi = 1'b0;
        expWcol = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, ev(0, 0, 0, 0), "ti_clr");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t z;
        z.v = 6'b0;
        #1;
        z.tag = "reset_state";
        checkOutput(z);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Mode 2, A5 with TB8=1, ticks every 16 clocks
        writeByte(8'hA5, 1'b1, 1'b1);
        tickBit(16, ev(1, 0, 0, 1), "m2_start");
        dataBits(8'hA5, 0, 7, 16);
        tickBit(16, ev(1, 1, 1, 1), "m2_tb8");
        tickBit(16, ev(1, 1, 1, 1), "m2_stop");
        expTi = 1'b1;
        tickBit(16, ev(0, 0, 0, 0), "m2_end_ti");
        idle(4);
        clearFlags();

        // Mode 0, 3C; terminating tick coincides with ti_clr, set must win
        writeByte(8'h3C, 1'b0, 1'b0);
        dataBits(8'h3C, 0, 7, 16);
        expTi = 1'b1;
        idle(15);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, ev(0, 0, 0, 0), "m0_end_ti_set_wins");
        idle(3);
        clearFlags();

        // Mid-frame write of FF during bit 3 is discarded
        writeByte(8'h5A, 1'b0, 1'b0);
        dataBits(8'h5A, 0, 3, 16);
        idle(5);
        expWcol = WcolOn;
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, ev(1, 1, 1'b1, 1), "midframe_write");
        dataBits(8'h5A, 4, 7, 16);
        expTi = 1'b1;
        tickBit(16, ev(0, 0, 0, 0), "collide_end_ti");
        idle(3);
        clearFlags();

        // Write coincident with the mode 2 stop terminating tick
        writeByte(8'h01, 1'b1, 1'b0);
        tickBit(16, ev(1, 0, 0, 1), "m2b_start");
        dataBits(8'h01, 0, 7, 16);
        tickBit(16, ev(1, 1, 0, 1), "m2b_tb8");
        tickBit(16, ev(1, 1, 1, 1), "m2b_stop");
        expTi = 1'b1;
        idle(15);
        applyStimulus(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, ev(0, 0, 0, 1), "write_on_stop_tick");
        dataBits(8'hC3, 0, 7, 16);
        tickBit(16, ev(0, 0, 0, 0), "back2back_end_ti");

        // Reset during DATA bit 4, with TI still set from the previous frame
        writeByte(8'hF0, 1'b0, 1'b0);
        dataBits(8'hF0, 0, 4, 16);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        z.tag = "async_reset_midframe";
        checkOutput(z);
        expTi = 1'b0;
        expWcol = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Clean frame after reset with ticks in consecutive clocks
        writeByte(8'h01, 1'b0, 1'b0);
        dataBits(8'h01, 0, 7, 1);
        expTi = 1'b1;
        tickBit(1, ev(0, 0, 0, 0), "fast_end_ti");
        idle(3);
        clearFlags();
        idle(3);

        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", scoreboard.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
